// File: rtl/ex_muldiv_ctrl_pkg.sv
// muldiv_pkg: op codes and sequencer states shared by the mul/div block
package muldiv_pkg;
  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULU = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_DIVU = 2'b11;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
endpackage

// File: rtl/ex_muldiv_ctrl_if.sv
// ex_muldiv_ctrl_if: EX-stage request/result bundle for the mul/div sequencer
interface ex_muldiv_ctrl_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             flush;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;
  modport master (output start, op, operand_a, operand_b, flush, input stall, done, hi, lo, div_zero);
  modport slave (input start, op, operand_a, operand_b, flush, output stall, done, hi, lo, div_zero);
endinterface

// File: rtl/ex_muldiv_ctrl_step.sv
// muldiv_step: one shift-add multiply or restoring-divide iteration
module muldiv_step #(parameter int WIDTH = 32) (
  input  logic             op_is_div,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] acc_hi_nxt,
  output logic [WIDTH-1:0] acc_lo_nxt
);
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] rem_sh;
  logic             ge;
  assign sum = acc_lo[0] ? {1'b0, acc_hi} + {1'b0, operand} : {1'b0, acc_hi};
  // the bit shifted out of the remainder makes it exceed any divisor
  assign rem_sh = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
  assign ge = acc_hi[WIDTH-1] | (rem_sh >= operand);
  assign acc_hi_nxt = op_is_div ? (ge ? rem_sh - operand : rem_sh) : sum[WIDTH:1];
  assign acc_lo_nxt = op_is_div ? {acc_lo[WIDTH-2:0], ge} : {sum[0], acc_lo[WIDTH-1:1]};
endmodule

// File: rtl/ex_muldiv_ctrl.sv
// ex_muldiv_ctrl: iterative MUL/MULU/DIV/DIVU sequencer stalling EX until HI/LO are ready
module ex_muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic               clock,
  input logic               reset,
  ex_muldiv_ctrl_if.slave   bus
);
  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [1:0]           op_q;
  logic [WIDTH-1:0]     operand, acc_hi, acc_lo, step_hi, step_lo, hi_q, lo_q;
  logic [WIDTH-1:0]     abs_a, abs_b, fix_hi, fix_lo;
  logic [2*WIDTH-1:0]   prod_fix;
  logic                 sign_q, sign_r, div_zero_q;
  logic                 accept, in_div, in_signed, dz_in, is_div;
  assign accept    = (state == IDLE) & bus.start & ~bus.flush;
  assign in_div    = bus.op inside {OP_DIV, OP_DIVU};
  assign in_signed = bus.op inside {OP_MUL, OP_DIV};
  assign dz_in     = in_div & (bus.operand_b == '0);
  assign abs_a     = (in_signed & bus.operand_a[WIDTH-1]) ? -bus.operand_a : bus.operand_a;
  assign abs_b     = (in_signed & bus.operand_b[WIDTH-1]) ? -bus.operand_b : bus.operand_b;
  assign is_div    = op_q inside {OP_DIV, OP_DIVU};
  // sign flags are only ever set for signed ops, so no op check is needed here
  assign prod_fix  = (~is_div & sign_q) ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
  assign fix_hi    = (is_div & sign_r) ? -acc_hi : prod_fix[2*WIDTH-1:WIDTH];
  assign fix_lo    = (is_div & sign_q) ? -acc_lo : prod_fix[WIDTH-1:0];
  assign bus.stall    = accept | (state == CALC) | (state == FIX);
  assign bus.done     = state == DONE;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.div_zero = div_zero_q;
  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op_is_div  (is_div),
    .acc_hi     (acc_hi),
    .acc_lo     (acc_lo),
    .operand    (operand),
    .acc_hi_nxt (step_hi),
    .acc_lo_nxt (step_lo)
  );
  // state register
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  // next state: divide-by-zero skips straight to DONE, flush aborts CALC/FIX
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = accept ? (dz_in ? DONE : CALC) : IDLE;
      CALC:    state_nxt = bus.flush ? IDLE : (cnt == CNT_W'(WIDTH - 1) ? FIX : CALC);
      FIX:     state_nxt = bus.flush ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
  end
  // operand capture, iteration accumulators and result registers
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      cnt        <= '0;
      op_q       <= '0;
      operand    <= '0;
      acc_hi     <= '0;
      acc_lo     <= '0;
      sign_q     <= 1'b0;
      sign_r     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q       <= bus.op;
        cnt        <= '0;
        acc_hi     <= '0;
        acc_lo     <= in_div ? abs_a : abs_b;
        operand    <= in_div ? abs_b : abs_a;
        sign_q     <= in_signed & (bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1]);
        sign_r     <= in_signed & bus.operand_a[WIDTH-1];
        div_zero_q <= dz_in;
        if (dz_in) begin
          hi_q <= bus.operand_a;
          lo_q <= '1;
        end
      end
      if (state == CALC) begin
        acc_hi <= step_hi;
        acc_lo <= step_lo;
        cnt    <= cnt + 1'b1;
      end
      if (state == FIX && !bus.flush) begin
        hi_q <= fix_hi;
        lo_q <= fix_lo;
      end
    end
endmodule
